// File: rtl/encoder_8to3_seq_if.sv
// Request/code bundle for encoder_8to3_seq: capture enable, request lines, ack in;
// encoded index, valid, pending snapshot and busy out.
interface encoder_8to3_seq_if;
  logic       e;
  logic [7:0] d;
  logic       ack;
  logic       a;
  logic       b;
  logic       c;
  logic       valid;
  logic [7:0] pending;
  logic       busy;

  modport master (
    output e, d, ack,
    input  a, b, c, valid, pending, busy
  );

  modport slave (
    input  e, d, ack,
    output a, b, c, valid, pending, busy
  );
endinterface

// File: rtl/encoder_8to3_seq.sv
// Registered 8-to-3 request encoder with sticky pending bits and a valid/ack handshake.
// Optional ENCODER_ROUND_ROBIN_EN replaces fixed highest-index priority with rotating priority.
module encoder_8to3_seq (
  input  logic                 clk,
  input  logic                 rst,
  encoder_8to3_seq_if.slave    bus
);

  typedef enum logic {IDLE, PRESENT} state_t;

  state_t     state_q;
  logic [7:0] pending_q;
  logic [7:0] pending_d;
  logic [2:0] code_q;
  logic       valid_q;
  logic [2:0] sel_idx;
  logic       load;
  logic [7:0] clear_mask;

  function automatic logic [2:0] sel_fixed(input logic [7:0] p);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (p[i]) idx = 3'(i);
    end
    return idx;
  endfunction

`ifdef ENCODER_ROUND_ROBIN_EN
  logic [2:0] last_idx_q;

  // Scan downward in offset so the last hit is the nearest index after last_idx.
  function automatic logic [2:0] sel_rr(input logic [7:0] p, input logic [2:0] start);
    logic [2:0] idx;
    logic [2:0] cand;
    idx = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      cand = start + 3'(k);
      if (p[cand]) idx = cand;
    end
    return idx;
  endfunction

  always_comb sel_idx = sel_rr(pending_q, last_idx_q + 3'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      last_idx_q <= 3'd7;
    end else if (load) begin
      last_idx_q <= sel_idx;
    end
  end
`else
  always_comb sel_idx = sel_fixed(pending_q);
`endif

  // A new index is loaded whenever something is pending and the output slot is free or being acked.
  always_comb begin
    load       = (pending_q != 8'h00) && ((state_q == IDLE) || bus.ack);
    clear_mask = load ? (8'h01 << sel_idx) : 8'h00;
    pending_d  = (pending_q & ~clear_mask) | (bus.e ? bus.d : 8'h00);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= 8'h00;
      code_q    <= 3'd0;
      valid_q   <= 1'b0;
    end else begin
      pending_q <= pending_d;
      case (state_q)
        IDLE: begin
          if (load) begin
            code_q  <= sel_idx;
            valid_q <= 1'b1;
            state_q <= PRESENT;
          end
        end
        PRESENT: begin
          if (bus.ack) begin
            if (load) begin
              code_q <= sel_idx;
            end else begin
              valid_q <= 1'b0;
              state_q <= IDLE;
            end
          end
        end
        default: begin
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.a       = code_q[2];
  assign bus.b       = code_q[1];
  assign bus.c       = code_q[0];
  assign bus.valid   = valid_q;
  assign bus.pending = pending_q;
  assign bus.busy    = valid_q | (|pending_q);

endmodule

// File: tb/tb_encoder_8to3_seq.sv
// Directed bench for encoder_8to3_seq: reset, single/multi-hot requests, enable gating,
// set-wins collision and priority ordering under a held two-bit request.
module tb_encoder_8to3_seq;
  logic clk;
  logic rst;
  int   errors;
  int   checks;

  encoder_8to3_seq_if bus ();

  encoder_8to3_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] code();
    return {5'd0, bus.a, bus.b, bus.c};
  endfunction

  logic [7:0] exp_seq [4];
  int         guard;

  initial begin
    errors  = 0;
    checks  = 0;
    rst     = 1'b1;
    bus.e   = 1'b0;
    bus.d   = 8'h00;
    bus.ack = 1'b0;
    tick();
    chk("rst_valid", {7'd0, bus.valid}, 8'h00);
    chk("rst_pending", bus.pending, 8'h00);
    chk("rst_code", code(), 8'h00);
    chk("rst_busy", {7'd0, bus.busy}, 8'h00);

    // Test 1: reset while presenting code 5
    rst   = 1'b0;
    bus.e = 1'b1;
    bus.d = 8'h20;
    tick();
    bus.d = 8'h00;
    tick();
    chk("t1_valid_pre", {7'd0, bus.valid}, 8'h01);
    chk("t1_code_pre", code(), 8'h05);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t1_valid_rst", {7'd0, bus.valid}, 8'h00);
    chk("t1_pending_rst", bus.pending, 8'h00);
    chk("t1_code_rst", code(), 8'h00);
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    chk("t1_ack_idle_valid", {7'd0, bus.valid}, 8'h00);
    chk("t1_ack_idle_busy", {7'd0, bus.busy}, 8'h00);

    // Test 2: single request, code held until ack
    bus.d = 8'h08;
    tick();
    bus.d = 8'h00;
    chk("t2_pending_e1", bus.pending, 8'h08);
    chk("t2_valid_e1", {7'd0, bus.valid}, 8'h00);
    tick();
    chk("t2_valid_e2", {7'd0, bus.valid}, 8'h01);
    chk("t2_code_e2", code(), 8'h03);
    chk("t2_pending_e2", bus.pending, 8'h00);
    chk("t2_busy_e2", {7'd0, bus.busy}, 8'h01);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_hold_code", code(), 8'h03);
      chk("t2_hold_valid", {7'd0, bus.valid}, 8'h01);
    end
    bus.ack = 1'b1;
    tick();
    chk("t2_ack_valid", {7'd0, bus.valid}, 8'h00);
    chk("t2_ack_code_hold", code(), 8'h03);

    // Test 3: multi-hot burst drained back-to-back, ack held high
    bus.d = 8'hA5;
    tick();
    bus.d = 8'h00;
    chk("t3_pending", bus.pending, 8'hA5);
    exp_seq = '{8'h07, 8'h05, 8'h02, 8'h00};
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t3_valid", {7'd0, bus.valid}, 8'h01);
      chk("t3_code", code(), exp_seq[i]);
    end
    tick();
    chk("t3_valid_end", {7'd0, bus.valid}, 8'h00);
    chk("t3_busy_end", {7'd0, bus.busy}, 8'h00);

    // Test 4: enable gating
    bus.ack = 1'b0;
    bus.e   = 1'b0;
    bus.d   = 8'hFF;
    tick();
    tick();
    chk("t4_gated_pending", bus.pending, 8'h00);
    chk("t4_gated_valid", {7'd0, bus.valid}, 8'h00);
    bus.e = 1'b1;
    bus.d = 8'h01;
    tick();
    bus.d = 8'h00;
    chk("t4_pending", bus.pending, 8'h01);
    chk("t4_valid_early", {7'd0, bus.valid}, 8'h00);
    tick();
    chk("t4_valid", {7'd0, bus.valid}, 8'h01);
    chk("t4_code", code(), 8'h00);
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    chk("t4_ack_valid", {7'd0, bus.valid}, 8'h00);

    // Test 5: set wins over clear on the loading edge
    bus.d = 8'h40;
    tick();
    chk("t5_pending_set", bus.pending, 8'h40);
    chk("t5_idle", {7'd0, bus.valid}, 8'h00);
    tick();
    bus.d = 8'h00;
    chk("t5_code", code(), 8'h06);
    chk("t5_valid", {7'd0, bus.valid}, 8'h01);
    chk("t5_pending_kept", bus.pending, 8'h40);
    bus.ack = 1'b1;
    tick();
    chk("t5_code_again", code(), 8'h06);
    chk("t5_valid_again", {7'd0, bus.valid}, 8'h01);
    chk("t5_pending_clr", bus.pending, 8'h00);
    tick();
    chk("t5_valid_end", {7'd0, bus.valid}, 8'h00);

    // Test 6: held 8'h81 with ack high
    bus.d = 8'h81;
    tick();
    chk("t6_pending", bus.pending, 8'h81);
`ifdef ENCODER_ROUND_ROBIN_EN
    exp_seq = '{8'h00, 8'h07, 8'h00, 8'h07};
`else
    exp_seq = '{8'h07, 8'h07, 8'h07, 8'h07};
`endif
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t6_valid", {7'd0, bus.valid}, 8'h01);
      chk("t6_code", code(), exp_seq[i]);
    end
    bus.d = 8'h00;
    guard = 0;
    while (bus.busy && guard < 10) begin
      tick();
      guard++;
    end
    chk("t6_drain_busy", {7'd0, bus.busy}, 8'h00);
    chk("t6_drain_cycles", 8'(guard), 8'h03);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/encoder_8to3_seq.md
Name: encoder_8to3_seq

Overview:
- Registered 8-to-3 request encoder. It is the inverse of the 3-to-8 enabled decoder.
- Captures one-hot or multi-hot request lines d0..d7 into sticky pending bits.
- Presents one pending index at a time as a 3-bit code on a/b/c (a = MSB), with a valid/ack handshake.
- Sits between request sources and any consumer of encoded indices, for example a decoder driving d0..d7 again downstream.

Parameters:
- none. Width is fixed at 8 requests / 3-bit code.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- e  input  1  capture enable; when 0, new requests are ignored
- d  input  8  request lines; bit i = request for index i (d[0]=d0 ... d[7]=d7)
- ack  input  1  consumer accepts the current code; meaningful only while valid=1
- a  output  1  code bit 2 (MSB)
- b  output  1  code bit 1
- c  output  1  code bit 0 (LSB)
- valid  output  1  {a,b,c} holds a pending index
- pending  output  8  current sticky pending register
- busy  output  1  valid=1 or pending != 0

Behaviour:
- Reset (rst=1 at an edge): pending=8'h00, a=b=c=0, valid=0, FSM=IDLE. Reset overrides every other input, including mid-handshake; a presented code is discarded without ack.
- Capture, every edge: pending_next = (pending & ~clear_mask) | (e ? d : 8'h00).
  - clear_mask is the one-hot bit of the index being loaded this edge, else 0.
  - Set wins over clear: if d[i]=1 with e=1 on the same edge that index i is loaded, pending[i] stays 1. That request is then presented again later.
- Selection, fixed priority: the highest-numbered set pending bit wins (d7 highest, d0 lowest).
  - Selection uses the registered pending value, not the raw d input.
- FSM IDLE:
  - valid=0.
  - If pending != 0: load {a,b,c}=selected index, set valid=1, clear that pending bit, go to PRESENT.
  - Else stay in IDLE.
- FSM PRESENT:
  - valid=1; {a,b,c} stable while ack=0.
  - On ack=1: if pending != 0, load the next selected index on the same edge, clear its bit, valid stays 1. This gives back-to-back throughput of 1 code per cycle.
  - On ack=1 with pending == 0: valid=0, {a,b,c} hold their last value, go to IDLE.
- Latency: d[i] high before edge k sets pending[i] after edge k. If IDLE, valid=1 with code i after edge k+1 (2 cycles from request).
- Multi-hot request: all bits are captured; codes are issued in descending index order, one per accepted handshake.
- Repeated request for an index already pending: merged; no counting and no overflow.
- e=0: capture blocked; already-pending bits continue draining normally.
- ack while valid=0: ignored.
- busy is combinational from registers: valid | (|pending).

Optional Feature:
- Macro: ENCODER_ROUND_ROBIN_EN
- Defined:
  - Rotating priority. A 3-bit last_idx register resets to 3'd7 and updates to each loaded index.
  - Selection searches pending starting at (last_idx+1) mod 8, increasing with wrap, so every requester is served within 8 grants.
- Not defined: fixed priority as above; no last_idx register is synthesized.

Test Plan:
1. Reset mid-PRESENT: valid=1, code 5, then rst=1 for 1 cycle -> next cycle valid=0, pending=0, {a,b,c}=000; ack=1 afterwards has no effect.
2. Single request, e=1: d=8'h08 for one cycle, ack held 0 -> pending=8'h08 after edge 1; valid=1, {a,b,c}=011, pending=0 after edge 2; code holds 011 for 5 idle cycles; ack=1 -> valid=0.
3. Multi-hot burst with ack tied 1: d=8'hA5 for one cycle -> codes 7,5,2,0 on consecutive cycles, valid high 4 cycles, then valid=0, busy=0.
4. Enable gating: e=0 with d=8'hFF -> pending stays 0, valid stays 0. Then e=1 with d=8'h01 -> code 000 two cycles later.
5. Set-wins collision: pending=8'h40, IDLE, with d=8'h40 on the loading edge -> code 110 presented and pending remains 8'h40. After ack, code 110 is presented again.
6. ENCODER_ROUND_ROBIN_EN defined: d held at 8'h81, ack=1 -> codes alternate 0,7,0,7 (fixed-priority build: 7,7,7...).
